// File: rtl/syn_dsp_pkg.sv
// syn_dsp_pkg: shared types and constants for the FFT frame scheduler
package syn_dsp_pkg;
  typedef enum logic [1:0] {FFT_SCHED_IDLE, FFT_SCHED_START, FFT_SCHED_FEED, FFT_SCHED_WAIT} fft_sched_state_e;
  localparam int FFT_SCHED_RD_LAT = 1;
endpackage

// File: rtl/syn_fft_skid_buf.sv
// syn_fft_skid_buf: 2-entry valid/ready output buffer; upstream is credit-limited so it never overflows
module syn_fft_skid_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        level
);
  logic [DATA_W-1:0] tail;
  logic pop;
  assign out_valid = level != 2'd0;
  assign pop = out_valid && out_ready;
  // head only moves on a pop, so data holds steady while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 2'd0;
      out_data <= '0;
      tail <= '0;
    end else begin
      level <= level + 2'(in_valid) - 2'(pop);
      if (in_valid && (level == 2'd0 || (level == 2'd1 && pop))) out_data <= in_data;
      else if (pop) out_data <= tail;
      if (in_valid && (level == 2'd2 || (level == 2'd1 && !pop))) tail <= in_data;
    end
  end
endmodule

// File: rtl/syn_fft_frame_sched.sv
// syn_fft_frame_sched: ping-pong PCM frame capture feeding the FFT core; SYN_FFT_SCHED_STATS_EN adds frame/drop counters
module syn_fft_frame_sched
  import syn_dsp_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_SAMPLES = 128,
  parameter int ADDR_W      = $clog2(NUM_SAMPLES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_en,
  input  logic              pcm_valid,
  input  logic [DATA_W-1:0] pcm_data,
  output logic              buf_wr_en,
  output logic [ADDR_W:0]   buf_wr_addr,
  output logic [DATA_W-1:0] buf_wr_data,
  output logic              buf_rd_en,
  output logic [ADDR_W:0]   buf_rd_addr,
  input  logic [DATA_W-1:0] buf_rd_data,
  output logic              fft_start,
  output logic              fft_sample_valid,
  output logic [DATA_W-1:0] fft_sample_data,
  output logic              fft_sample_last,
  input  logic              fft_ready,
  input  logic              fft_done,
  output logic              busy,
  output logic              ovrflw
`ifdef SYN_FFT_SCHED_STATS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       drop_cnt
`endif
);
  fft_sched_state_e state;
  logic wr_bank, rd_bank, wr_wrap, rel, pop, rd_v, rd_last, credit;
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W:0] rd_cnt;
  logic [1:0] bank_full, set_mask, clr_mask, level;
  logic [DATA_W:0] head;
  assign buf_wr_en = cfg_en && pcm_valid && !bank_full[wr_bank];
  assign ovrflw = cfg_en && pcm_valid && bank_full[wr_bank];
  assign buf_wr_addr = {wr_bank, wr_idx};
  assign buf_wr_data = buf_wr_en ? pcm_data : '0;
  assign wr_wrap = buf_wr_en && wr_idx == ADDR_W'(NUM_SAMPLES - 1);
  assign rel = state == FFT_SCHED_WAIT && fft_done;
  assign set_mask = {wr_wrap && wr_bank, wr_wrap && !wr_bank};
  assign clr_mask = {rel && rd_bank, rel && !rd_bank};
  assign busy = state != FFT_SCHED_IDLE;
  assign pop = fft_sample_valid && fft_ready;
  // a read may issue only if its data is guaranteed a buffer slot, counting the slot freed this cycle
  assign credit = ({1'b0, level} + {2'b0, rd_v}) < (3'd2 + {2'b0, pop});
  assign buf_rd_en = (state == FFT_SCHED_START || state == FFT_SCHED_FEED) && !rd_cnt[ADDR_W] && credit;
  assign buf_rd_addr = {rd_bank, rd_cnt[ADDR_W-1:0]};
  assign fft_sample_data = head[DATA_W-1:0];
  assign fft_sample_last = fft_sample_valid && head[DATA_W];
  // write pointer and bank occupancy; writer set and reader release apply together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      wr_idx <= '0;
      bank_full <= 2'b00;
    end else begin
      bank_full <= (bank_full | set_mask) & ~clr_mask;
      wr_idx <= !cfg_en || wr_wrap ? '0 : buf_wr_en ? wr_idx + ADDR_W'(1) : wr_idx;
      if (wr_wrap) wr_bank <= ~wr_bank;
    end
  end
  // track the read issued last cycle so its returning data lands in the buffer with its last flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v <= 1'b0;
      rd_last <= 1'b0;
    end else begin
      rd_v <= buf_rd_en;
      rd_last <= buf_rd_en && rd_cnt == (ADDR_W + 1)'(NUM_SAMPLES - 1);
    end
  end
  // read FSM: start pulse, stream the full bank, then hold the bank until the FFT signals done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FFT_SCHED_IDLE;
      rd_bank <= 1'b0;
      rd_cnt <= '0;
      fft_start <= 1'b0;
    end else begin
      fft_start <= state == FFT_SCHED_IDLE && cfg_en && bank_full[rd_bank];
      rd_cnt <= state == FFT_SCHED_IDLE ? '0 : rd_cnt + {{ADDR_W{1'b0}}, buf_rd_en};
      case (state)
        FFT_SCHED_IDLE:  if (cfg_en && bank_full[rd_bank]) state <= FFT_SCHED_START;
        FFT_SCHED_START: state <= FFT_SCHED_FEED;
        FFT_SCHED_FEED:  if (pop && fft_sample_last) state <= FFT_SCHED_WAIT;
        default: if (fft_done) begin
          state <= FFT_SCHED_IDLE;
          rd_bank <= ~rd_bank;
        end
      endcase
    end
  end
  syn_fft_skid_buf #(.DATA_W(DATA_W + 1)) u_skid (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(rd_v),
    .in_data({rd_last, buf_rd_data}),
    .out_ready(fft_ready),
    .out_valid(fft_sample_valid),
    .out_data(head),
    .level(level)
  );
`ifdef SYN_FFT_SCHED_STATS_EN
  // saturating counts of completed frames and dropped samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + 16'(rel && frame_cnt != 16'hFFFF);
      drop_cnt <= drop_cnt + 16'(ovrflw && drop_cnt != 16'hFFFF);
    end
  end
`endif
endmodule

// File: tb/tb_syn_fft_frame_sched.sv
// tb_syn_fft_frame_sched: scoreboard bench for the FFT frame scheduler with NUM_SAMPLES=8
module tb_syn_fft_frame_sched;
  logic clk = 1'b0;
  logic rst_n, cfg_en, pcm_valid, fft_ready, fft_done;
  logic [31:0] pcm_data, buf_rd_data, buf_wr_data, fft_sample_data;
  logic buf_wr_en, buf_rd_en, fft_start, fft_sample_valid, fft_sample_last, busy, ovrflw;
  logic [3:0] buf_wr_addr, buf_rd_addr;
  logic [31:0] mem [16];
  logic [31:0] q[$];
  logic [31:0] prev_data, exp_d;
  logic prev_stall, exp_bank, first_pending;
  int pass_cnt = 0, total_cnt = 0;
  int cyc = 0, s_cyc, start_cyc, first_cyc, last_cyc;
  int n_start = 0, hs_cnt = 0, last_cnt = 0, ov_cnt = 0, frame_hs = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  syn_fft_frame_sched #(.DATA_W(32), .NUM_SAMPLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .pcm_valid(pcm_valid), .pcm_data(pcm_data),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
    .fft_start(fft_start), .fft_sample_valid(fft_sample_valid), .fft_sample_data(fft_sample_data),
    .fft_sample_last(fft_sample_last), .fft_ready(fft_ready), .fft_done(fft_done),
    .busy(busy), .ovrflw(ovrflw)
  );

  // sample RAM with one-cycle read latency
  always @(posedge clk) begin
    if (buf_wr_en) mem[buf_wr_addr] <= buf_wr_data;
    if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];
  end

  // FFT-side monitor: scoreboard pops, last flag, stall stability, start bank
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      frame_hs = 0;
      exp_bank = 1'b0;
      first_pending = 1'b0;
    end else begin
      if (prev_stall) begin
        total_cnt++;
        if (!fft_sample_valid || fft_sample_data !== prev_data)
          $display("FAIL stall_hold: valid=%0b data=%0d, required valid=1 data=%0d", fft_sample_valid, fft_sample_data, prev_data);
        else pass_cnt++;
      end
      if (fft_start) begin
        n_start++;
        start_cyc = cyc;
        first_pending = 1'b1;
        total_cnt++;
        if (buf_rd_en !== 1'b1 || buf_rd_addr !== {exp_bank, 3'b000})
          $display("FAIL start_bank: rd_en=%0b rd_addr=%0h, required rd_en=1 rd_addr=%0h", buf_rd_en, buf_rd_addr, {exp_bank, 3'b000});
        else pass_cnt++;
        exp_bank = ~exp_bank;
      end
      if (fft_sample_valid && first_pending) begin
        first_cyc = cyc;
        first_pending = 1'b0;
      end
      if (fft_sample_valid && fft_ready) begin
        hs_cnt++;
        total_cnt++;
        if (q.size() == 0) $display("FAIL sample_extra: got %0d, required no sample", fft_sample_data);
        else begin
          exp_d = q.pop_front();
          if (fft_sample_data !== exp_d || fft_sample_last !== (frame_hs == 7))
            $display("FAIL sample: data=%0d last=%0b, required data=%0d last=%0b", fft_sample_data, fft_sample_last, exp_d, frame_hs == 7);
          else pass_cnt++;
        end
        frame_hs = frame_hs == 7 ? 0 : frame_hs + 1;
        if (fft_sample_last) begin
          last_cnt++;
          last_cyc = cyc;
        end
      end
      if (ovrflw) ov_cnt++;
      prev_stall = fft_sample_valid && !fft_ready;
      prev_data = fft_sample_data;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    pcm_valid = 1'b0;
    pcm_data = '0;
    cfg_en = 1'b1;
    fft_ready = 1'b1;
    fft_done = 1'b0;
    q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic exp_wr, input logic [3:0] exp_addr, input logic exp_ov, input logic push);
    pcm_valid = 1'b1;
    pcm_data = d;
    if (push) q.push_back(d);
    @(negedge clk);
    s_cyc = cyc;
    total_cnt++;
    if (buf_wr_en !== exp_wr || ovrflw !== exp_ov || (exp_wr && (buf_wr_addr !== exp_addr || buf_wr_data !== d)))
      $display("FAIL write(%0d): wr_en=%0b addr=%0h data=%0d ovrflw=%0b, required wr_en=%0b addr=%0h data=%0d ovrflw=%0b",
               d, buf_wr_en, buf_wr_addr, buf_wr_data, ovrflw, exp_wr, exp_addr, d, exp_ov);
    else pass_cnt++;
    @(posedge clk);
    #1;
    pcm_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_last(input int target);
    int n = 0;
    while (last_cnt < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (last_cnt < target) $display("FAIL last_timeout: last count %0d, required %0d", last_cnt, target);
    else pass_cnt++;
  endtask

  task automatic pulse_done();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    fft_done = 1'b1;
    @(posedge clk);
    #1;
    fft_done = 1'b0;
  endtask

  task automatic check_empty(input string name);
    total_cnt++;
    if (q.size() != 0) $display("FAIL %s_leftover: %0d samples pending, required 0", name, q.size());
    else pass_cnt++;
  endtask

  task automatic check_outs_zero(input string name);
    total_cnt++;
    if ({buf_wr_en, buf_wr_addr, buf_wr_data, buf_rd_en, buf_rd_addr, fft_start, fft_sample_valid,
         fft_sample_data, fft_sample_last, busy, ovrflw} !== '0)
      $display("FAIL %s: wr_en=%0b wr_addr=%0h wr_data=%0h rd_en=%0b rd_addr=%0h start=%0b valid=%0b data=%0h last=%0b busy=%0b ovrflw=%0b, required all 0",
               name, buf_wr_en, buf_wr_addr, buf_wr_data, buf_rd_en, buf_rd_addr, fft_start, fft_sample_valid,
               fft_sample_data, fft_sample_last, busy, ovrflw);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pcm_valid = 1'b0;
    pcm_data = '0;
    cfg_en = 1'b0;
    fft_ready = 1'b0;
    fft_done = 1'b0;
    #2;
    check_outs_zero("reset_state");
    do_reset();
    check_outs_zero("after_reset");
  endtask

  task automatic test_single_frame();
    int base, s8;
    do_reset();
    base = last_cnt;
    for (int i = 1; i <= 8; i++) send(32'(i), 1'b1, {1'b0, 3'(i - 1)}, 1'b0, 1'b1);
    s8 = s_cyc;
    wait_last(base + 1);
    total_cnt++;
    if (start_cyc - s8 != 2 || first_cyc - start_cyc != 2 || last_cyc - first_cyc != 7)
      $display("FAIL latency: start-write=%0d valid-start=%0d last-first=%0d, required 2 2 7", start_cyc - s8, first_cyc - start_cyc, last_cyc - first_cyc);
    else pass_cnt++;
    pulse_done();
    idle(1);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL idle_after_done: busy=%0b, required 0", busy);
    else pass_cnt++;
    check_empty("single");
  endtask

  task automatic test_continuous();
    int base = last_cnt, ov0 = ov_cnt, st0 = n_start;
    do_reset();
    base = last_cnt;
    fork
      for (int i = 1; i <= 24; i++) begin
        send(32'(i), 1'b1, {1'(((i - 1) / 8) % 2), 3'((i - 1) % 8)}, 1'b0, 1'b1);
        idle(1);
      end
      for (int f = 1; f <= 3; f++) begin
        wait_last(base + f);
        pulse_done();
      end
    join
    total_cnt++;
    if (ov_cnt - ov0 != 0 || n_start - st0 != 3)
      $display("FAIL continuous: ovrflw=%0d starts=%0d, required 0 and 3", ov_cnt - ov0, n_start - st0);
    else pass_cnt++;
    check_empty("continuous");
  endtask

  task automatic test_overflow();
    int base, ov0;
    do_reset();
    base = last_cnt;
    ov0 = ov_cnt;
    for (int i = 1; i <= 20; i++)
      send(32'(i), i <= 16, {1'(i > 8), 3'((i - 1) % 8)}, i > 16, i <= 16);
    wait_last(base + 1);
    @(posedge clk);
    #1;
    fft_done = 1'b1;
    @(posedge clk);
    #1;
    fft_done = 1'b0;
    send(32'd21, 1'b1, 4'h0, 1'b0, 1'b0);
    wait_last(base + 2);
    pulse_done();
    total_cnt++;
    if (ov_cnt - ov0 != 4) $display("FAIL overflow_count: %0d, required 4", ov_cnt - ov0);
    else pass_cnt++;
    check_empty("overflow");
  endtask

  task automatic test_ready_toggle();
    int base, h0;
    do_reset();
    base = last_cnt;
    h0 = hs_cnt;
    fork
      for (int i = 1; i <= 8; i++) send(32'(40 + i), 1'b1, {1'b0, 3'(i - 1)}, 1'b0, 1'b1);
      begin
        int n = 0;
        while (last_cnt < base + 1 && n < 200) begin
          @(posedge clk);
          #1;
          fft_ready = ~fft_ready;
          n++;
        end
      end
    join
    fft_ready = 1'b1;
    wait_last(base + 1);
    pulse_done();
    total_cnt++;
    if (hs_cnt - h0 != 8) $display("FAIL toggle_handshakes: %0d, required 8", hs_cnt - h0);
    else pass_cnt++;
    check_empty("toggle");
  endtask

  task automatic test_cfg_en();
    int base, st0, ov0;
    do_reset();
    base = last_cnt;
    st0 = n_start;
    ov0 = ov_cnt;
    for (int i = 1; i <= 5; i++) send(32'(i), 1'b1, {1'b0, 3'(i - 1)}, 1'b0, 1'b0);
    cfg_en = 1'b0;
    for (int i = 6; i <= 7; i++) send(32'(i), 1'b0, 4'h0, 1'b0, 1'b0);
    cfg_en = 1'b1;
    for (int i = 1; i <= 8; i++) send(32'(100 + i), 1'b1, {1'b0, 3'(i - 1)}, 1'b0, 1'b1);
    wait_last(base + 1);
    pulse_done();
    idle(2);
    total_cnt++;
    if (n_start - st0 != 1 || ov_cnt - ov0 != 0)
      $display("FAIL cfg_en_frames: starts=%0d ovrflw=%0d, required 1 and 0", n_start - st0, ov_cnt - ov0);
    else pass_cnt++;
    check_empty("cfg_en");
  endtask

  task automatic test_reset_mid_feed();
    int base, h0, n, s8;
    do_reset();
    h0 = hs_cnt;
    for (int i = 1; i <= 8; i++) send(32'(i), 1'b1, {1'b0, 3'(i - 1)}, 1'b0, 1'b1);
    n = 0;
    while (hs_cnt < h0 + 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    check_outs_zero("mid_feed_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    base = last_cnt;
    for (int i = 9; i <= 16; i++) send(32'(i), 1'b1, {1'b0, 3'(i - 9)}, 1'b0, 1'b1);
    s8 = s_cyc;
    wait_last(base + 1);
    total_cnt++;
    if (start_cyc - s8 != 2) $display("FAIL restart_latency: %0d, required 2", start_cyc - s8);
    else pass_cnt++;
    pulse_done();
    check_empty("mid_feed");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_continuous();
    test_overflow();
    test_ready_toggle();
    test_cfg_en();
    test_reset_mid_feed();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
